unified_mem_arbiter: RTL

Shares one single-ported unified memory between the SCC instruction-fetch port (`in_mem_addr`/`in_mem`) and its data port (`data_addr`/`data_in`/`data_out`, `data_read`/`data_write`). It sits between the SCC top level and the memory model. Each requester gets a req/ready handshake, and the memory gets an en/ack handshake. Data accesses have priority, with a starvation guard so fetch is never locked out.

---
 rtl/arb_pkg.sv | 12 +
 rtl/arb_watchdog.sv | 32 +++
 rtl/unified_mem_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_D  = 2'd2
    } arb_state_t;

    localparam logic [31:0] ARB_ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_watchdog.sv
// Ack watchdog: loads on grant entry, counts down each grant cycle and flags
// expiry on the TIMEOUT-th cycle spent waiting. Used only with UNIFIED_MEM_ARB_TIMEOUT_EN.
module arb_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic expire
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] count;
    logic          running;

    // Loaded with TIMEOUT-1 so the count reaches zero in the TIMEOUT-th grant cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            running <= 1'b0;
            count   <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= CW'(TIMEOUT - 1);
        end else if (running && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expire = running && (count == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between SCC fetch and data ports; data has
// priority with a starvation guard. Optional ack watchdog: UNIFIED_MEM_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no access outstanding, arbitrate every cycle
// GNT_IF | fetch access issued, waiting for mem_ack
// GNT_D  | data access issued, waiting for mem_ack
module unified_mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 3,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);
    localparam int SW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [SW-1:0]     STARVE_MAX = SW'(MAX_WAIT);
    localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(ARB_ABORT_DATA);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    arb_state_t    state;
    logic [SW-1:0] starve_cnt;
    logic          in_grant;
    logic          abort;
    logic          done;
    logic          pick_d;
    logic          pick_if;

    assign in_grant = (state == GNT_IF) || (state == GNT_D);

`ifdef UNIFIED_MEM_ARB_TIMEOUT_EN
    logic grant_start;
    logic expire;

    assign grant_start = (state == IDLE) && (d_req || if_req);

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .start  (grant_start),
        .clear  (done),
        .expire (expire)
    );

    // A late ack landing on the expiry cycle is treated as a normal completion.
    assign abort = in_grant && expire && !mem_ack;
`else
    assign abort = 1'b0;
`endif

    assign done     = in_grant && (mem_ack || abort);
    assign err      = abort;
    assign if_ready = (state == GNT_IF) && (mem_ack || abort);
    assign d_ready  = (state == GNT_D)  && (mem_ack || abort);
    assign if_rdata = !if_ready ? '0 : (abort ? ABORT_DATA : mem_rdata);
    assign d_rdata  = !d_ready  ? '0 : (abort ? ABORT_DATA : mem_rdata);

    assign pick_d  = d_req && !(if_req && (starve_cnt == STARVE_MAX));
    assign pick_if = if_req && !pick_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state     <= GNT_D;
                        mem_en    <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        // pick_d with if_req pending implies the counter is below MAX_WAIT
                        if (if_req) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else if (pick_if) begin
                        state      <= GNT_IF;
                        mem_en     <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        starve_cnt <= '0;
                    end
                end
                GNT_IF, GNT_D: begin
                    if (done) begin
                        state  <= IDLE;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
